// File: rtl/reqrsp_demux.sv
// ============================================================================
//  Module      : reqrsp_demux
//  Description : Routes one reqrsp slave port onto NR_PORTS master ports by a
//                per-request select; responses return in request order via a
//                small select FIFO. Define REQRSP_DEMUX_ASSERT_EN to compile in
//                simulation assertions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reqrsp_demux #(
    parameter  int unsigned NR_PORTS    = 4,
    parameter  int unsigned ADDR_WIDTH  = 32,
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned RESP_DEPTH  = 2,
    localparam int unsigned SEL_WIDTH   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,

    input  logic [SEL_WIDTH-1:0]             slv_select_i,
    input  logic [ADDR_WIDTH-1:0]            slv_q_addr_i,
    input  logic                             slv_q_write_i,
    input  logic [3:0]                       slv_q_amo_i,
    input  logic [DATA_WIDTH-1:0]            slv_q_data_i,
    input  logic [STRB_WIDTH-1:0]            slv_q_strb_i,
    input  logic [1:0]                       slv_q_size_i,
    input  logic                             slv_q_valid_i,
    output logic                             slv_q_ready_o,

    output logic [DATA_WIDTH-1:0]            slv_p_data_o,
    output logic                             slv_p_error_o,
    output logic                             slv_p_valid_o,
    input  logic                             slv_p_ready_i,

    output logic [NR_PORTS*ADDR_WIDTH-1:0]   mst_q_addr_o,
    output logic [NR_PORTS-1:0]              mst_q_write_o,
    output logic [NR_PORTS*4-1:0]            mst_q_amo_o,
    output logic [NR_PORTS*DATA_WIDTH-1:0]   mst_q_data_o,
    output logic [NR_PORTS*STRB_WIDTH-1:0]   mst_q_strb_o,
    output logic [NR_PORTS*2-1:0]            mst_q_size_o,
    output logic [NR_PORTS-1:0]              mst_q_valid_o,
    input  logic [NR_PORTS-1:0]              mst_q_ready_i,

    input  logic [NR_PORTS*DATA_WIDTH-1:0]   mst_p_data_i,
    input  logic [NR_PORTS-1:0]              mst_p_error_i,
    input  logic [NR_PORTS-1:0]              mst_p_valid_i,
    output logic [NR_PORTS-1:0]              mst_p_ready_o
);

    localparam int unsigned c_PTR_WIDTH = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned c_CNT_WIDTH = $clog2(RESP_DEPTH + 1);

    logic [SEL_WIDTH-1:0]   r_sel_mem [RESP_DEPTH];
    logic [c_PTR_WIDTH-1:0] r_wptr;
    logic [c_PTR_WIDTH-1:0] r_rptr;
    logic [c_CNT_WIDTH-1:0] r_cnt;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_sel_ok;
    logic [SEL_WIDTH-1:0]   w_head;
    logic                   w_push;
    logic                   w_pop;
    logic [c_PTR_WIDTH-1:0] w_wptr_nxt;
    logic [c_PTR_WIDTH-1:0] w_rptr_nxt;

    assign w_full   = (r_cnt == c_CNT_WIDTH'(RESP_DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign w_sel_ok = (32'(slv_select_i) < NR_PORTS);
    assign w_head   = r_sel_mem[r_rptr];

    // Payload is broadcast; only the valid is steered.
    assign mst_q_addr_o  = {NR_PORTS{slv_q_addr_i}};
    assign mst_q_write_o = {NR_PORTS{slv_q_write_i}};
    assign mst_q_amo_o   = {NR_PORTS{slv_q_amo_i}};
    assign mst_q_data_o  = {NR_PORTS{slv_q_data_i}};
    assign mst_q_strb_o  = {NR_PORTS{slv_q_strb_i}};
    assign mst_q_size_o  = {NR_PORTS{slv_q_size_i}};

    always_comb begin
        mst_q_valid_o = '0;
        if (slv_q_valid_i && w_sel_ok && !w_full) begin
            mst_q_valid_o[slv_select_i] = 1'b1;
        end
    end

    // Ready ignores the pop of the current cycle so no p_ready->q_ready path exists.
    assign slv_q_ready_o = w_sel_ok && !w_full && mst_q_ready_i[slv_select_i];

    assign slv_p_valid_o = !w_empty && mst_p_valid_i[w_head];
    assign slv_p_data_o  = mst_p_data_i[w_head*DATA_WIDTH +: DATA_WIDTH];
    assign slv_p_error_o = mst_p_error_i[w_head];

    always_comb begin
        mst_p_ready_o = '0;
        if (!w_empty && slv_p_ready_i) begin
            mst_p_ready_o[w_head] = 1'b1;
        end
    end

    assign w_push     = slv_q_valid_i && slv_q_ready_o;
    assign w_pop      = slv_p_valid_o && slv_p_ready_i;
    assign w_wptr_nxt = (r_wptr == c_PTR_WIDTH'(RESP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == c_PTR_WIDTH'(RESP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_sel_mem[r_wptr] <= slv_select_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

`ifdef REQRSP_DEMUX_ASSERT_EN
    a_q_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slv_q_valid_i && !slv_q_ready_o) |=>
            $stable({slv_select_i, slv_q_addr_i, slv_q_write_i, slv_q_amo_i,
                     slv_q_data_i, slv_q_strb_i, slv_q_size_i}));

    a_sel_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        slv_q_valid_i |-> w_sel_ok);

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_push |-> !w_full);

    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_pop |-> !w_empty);

    for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_assert_head
        a_head_only : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (mst_p_valid_i[gi] && mst_p_ready_o[gi]) |-> (w_head == SEL_WIDTH'(gi)));
    end
`else
    // Assertions compiled out; datapath is unchanged.
`endif

endmodule

`default_nettype wire

// File: tb/tb_reqrsp_demux.sv
// ============================================================================
//  Module      : tb_reqrsp_demux
//  Description : Self-checking bench for reqrsp_demux: directed cases plus
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reqrsp_demux;

    localparam int NP    = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int NREQ  = 1000;

    logic              clk_i;
    logic              rst_ni;
    logic [1:0]        slv_select_i;
    logic [AW-1:0]     slv_q_addr_i;
    logic              slv_q_write_i;
    logic [3:0]        slv_q_amo_i;
    logic [DW-1:0]     slv_q_data_i;
    logic [DW/8-1:0]   slv_q_strb_i;
    logic [1:0]        slv_q_size_i;
    logic              slv_q_valid_i;
    logic              slv_q_ready_o;
    logic [DW-1:0]     slv_p_data_o;
    logic              slv_p_error_o;
    logic              slv_p_valid_o;
    logic              slv_p_ready_i;
    logic [NP*AW-1:0]  mst_q_addr_o;
    logic [NP-1:0]     mst_q_write_o;
    logic [NP*4-1:0]   mst_q_amo_o;
    logic [NP*DW-1:0]  mst_q_data_o;
    logic [NP*DW/8-1:0] mst_q_strb_o;
    logic [NP*2-1:0]   mst_q_size_o;
    logic [NP-1:0]     mst_q_valid_o;
    logic [NP-1:0]     mst_q_ready_i;
    logic [NP*DW-1:0]  mst_p_data_i;
    logic [NP-1:0]     mst_p_error_i;
    logic [NP-1:0]     mst_p_valid_i;
    logic [NP-1:0]     mst_p_ready_o;

    reqrsp_demux #(
        .NR_PORTS   (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESP_DEPTH (DEPTH)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .slv_select_i  (slv_select_i),
        .slv_q_addr_i  (slv_q_addr_i),
        .slv_q_write_i (slv_q_write_i),
        .slv_q_amo_i   (slv_q_amo_i),
        .slv_q_data_i  (slv_q_data_i),
        .slv_q_strb_i  (slv_q_strb_i),
        .slv_q_size_i  (slv_q_size_i),
        .slv_q_valid_i (slv_q_valid_i),
        .slv_q_ready_o (slv_q_ready_o),
        .slv_p_data_o  (slv_p_data_o),
        .slv_p_error_o (slv_p_error_o),
        .slv_p_valid_o (slv_p_valid_o),
        .slv_p_ready_i (slv_p_ready_i),
        .mst_q_addr_o  (mst_q_addr_o),
        .mst_q_write_o (mst_q_write_o),
        .mst_q_amo_o   (mst_q_amo_o),
        .mst_q_data_o  (mst_q_data_o),
        .mst_q_strb_o  (mst_q_strb_o),
        .mst_q_size_o  (mst_q_size_o),
        .mst_q_valid_o (mst_q_valid_o),
        .mst_q_ready_i (mst_q_ready_i),
        .mst_p_data_i  (mst_p_data_i),
        .mst_p_error_i (mst_p_error_i),
        .mst_p_valid_i (mst_p_valid_i),
        .mst_p_ready_o (mst_p_ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: selects of outstanding requests, oldest first.
    int          m_q [$];
    logic [32:0] exp_rsp [$];
    logic [31:0] pend [NP][$];

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [32:0] rsp_of(input logic [31:0] addr);
        return {addr[5] ^ addr[9], addr ^ 32'hC3A5_0F96};
    endfunction

    // Compare all combinational outputs with the model, then advance the model.
    task automatic check_cycle();
        int          n;
        int          head;
        bit          full;
        bit          empty;
        bit          ok;
        logic [3:0]  e_qv;
        logic [3:0]  e_pr;
        logic        e_qr;
        logic        e_pv;
        #1;
        n     = m_q.size();
        full  = (n == DEPTH);
        empty = (n == 0);
        head  = empty ? 0 : m_q[0];
        ok    = (int'(slv_select_i) < NP) && !full;
        e_qv  = (slv_q_valid_i && ok) ? (4'b0001 << slv_select_i) : 4'b0000;
        e_qr  = ok && mst_q_ready_i[slv_select_i];
        e_pv  = !empty && mst_p_valid_i[head];
        e_pr  = (!empty && slv_p_ready_i) ? (4'b0001 << head) : 4'b0000;
        check_eq("mst_q_valid", 128'(mst_q_valid_o), 128'(e_qv));
        check_eq("slv_q_ready", 128'(slv_q_ready_o), 128'(e_qr));
        check_eq("slv_p_valid", 128'(slv_p_valid_o), 128'(e_pv));
        check_eq("mst_p_ready", 128'(mst_p_ready_o), 128'(e_pr));
        if (e_pv) begin
            check_eq("slv_p_data", 128'(slv_p_data_o), 128'(mst_p_data_i[head*DW +: DW]));
            check_eq("slv_p_error", 128'(slv_p_error_o), 128'(mst_p_error_i[head]));
        end
        check_eq("bcast_addr", 128'(mst_q_addr_o), 128'({NP{slv_q_addr_i}}));
        check_eq("bcast_data", 128'(mst_q_data_o), 128'({NP{slv_q_data_i}}));
        check_eq("bcast_ctrl", 128'({mst_q_write_o, mst_q_amo_o, mst_q_strb_o, mst_q_size_o}),
                 128'({{NP{slv_q_write_i}}, {NP{slv_q_amo_i}}, {NP{slv_q_strb_i}}, {NP{slv_q_size_i}}}));
        if (slv_q_valid_i && e_qr) m_q.push_back(int'(slv_select_i));
        if (e_pv && slv_p_ready_i) void'(m_q.pop_front());
    endtask

    task automatic set_req(input logic v, input logic [1:0] sel, input logic [31:0] addr, input logic wr);
        slv_q_valid_i = v;
        slv_select_i  = sel;
        slv_q_addr_i  = addr;
        slv_q_write_i = wr;
        slv_q_data_i  = addr ^ 32'h1234_5678;
    endtask

    initial begin
        int          sent;
        int          rcvd;
        int          cyc;
        int          total;
        bit          hold;
        logic [32:0] exp_v;
        logic [31:0] a;

        rst_ni        = 1'b0;
        set_req(1'b0, 2'd0, 32'h0, 1'b0);
        slv_q_amo_i   = 4'h0;
        slv_q_strb_i  = 4'hF;
        slv_q_size_i  = 2'd2;
        slv_p_ready_i = 1'b0;
        mst_q_ready_i = '0;
        mst_p_data_i  = '0;
        mst_p_error_i = '0;
        mst_p_valid_i = '0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // Idle after reset: nothing valid, FIFO empty so ready follows port ready.
        mst_q_ready_i = 4'b0001;
        check_cycle();
        check_eq("rst_mst_q_valid", 128'(mst_q_valid_o), 128'(0));
        check_eq("rst_slv_p_valid", 128'(slv_p_valid_o), 128'(0));
        check_eq("rst_q_ready", 128'(slv_q_ready_o), 128'(1));
        @(negedge clk_i);

        // Single write to port 2.
        set_req(1'b1, 2'd2, 32'h6, 1'b1);
        mst_q_ready_i = 4'b0100;
        check_cycle();
        check_eq("wr2_q_valid", 128'(mst_q_valid_o), 128'(4'b0100));
        @(negedge clk_i);
        set_req(1'b0, 2'd0, 32'h0, 1'b0);
        mst_p_valid_i = 4'b0100;
        mst_p_data_i[2*DW +: DW] = 32'hAB;
        slv_p_ready_i = 1'b1;
        check_cycle();
        check_eq("wr2_p_data", 128'(slv_p_data_o), 128'(32'hAB));
        check_eq("wr2_p_valid", 128'(slv_p_valid_o), 128'(1));
        @(negedge clk_i);
        check_cycle();
        check_eq("wr2_empty", 128'(slv_p_valid_o), 128'(0));
        @(negedge clk_i);
        mst_p_valid_i = '0;

        // Fill to depth with ports 1 and 3, third request must stall.
        mst_q_ready_i = 4'b1111;
        slv_p_ready_i = 1'b0;
        set_req(1'b1, 2'd1, 32'h101, 1'b0);
        check_cycle();
        @(negedge clk_i);
        set_req(1'b1, 2'd3, 32'h303, 1'b0);
        check_cycle();
        @(negedge clk_i);
        set_req(1'b1, 2'd0, 32'h400, 1'b1);
        check_cycle();
        check_eq("full_q_ready", 128'(slv_q_ready_o), 128'(0));
        @(negedge clk_i);

        // Port 3 answers first and must be held behind port 1.
        mst_p_valid_i = 4'b1000;
        mst_p_data_i[3*DW +: DW] = 32'h33;
        slv_p_ready_i = 1'b1;
        check_cycle();
        check_eq("ooo_p_ready", 128'(mst_p_ready_o), 128'(4'b0010));
        check_eq("ooo_p_valid", 128'(slv_p_valid_o), 128'(0));
        @(negedge clk_i);
        mst_p_valid_i = 4'b1010;
        mst_p_data_i[1*DW +: DW] = 32'h11;
        check_cycle();
        check_eq("ooo_first", 128'(slv_p_data_o), 128'(32'h11));
        check_eq("full_pop_q_ready", 128'(slv_q_ready_o), 128'(0));
        @(negedge clk_i);
        mst_p_valid_i = 4'b1000;
        check_cycle();
        check_eq("ooo_second", 128'(slv_p_data_o), 128'(32'h33));
        check_eq("third_accept", 128'(slv_q_ready_o), 128'(1));
        @(negedge clk_i);

        // Error response from port 0.
        set_req(1'b0, 2'd0, 32'h0, 1'b0);
        mst_p_valid_i = 4'b0001;
        mst_p_data_i[0*DW +: DW] = 32'hDEAD;
        mst_p_error_i = 4'b0001;
        check_cycle();
        check_eq("err_flag", 128'(slv_p_error_o), 128'(1));
        check_eq("err_data", 128'(slv_p_data_o), 128'(32'hDEAD));
        @(negedge clk_i);
        mst_p_valid_i = '0;
        mst_p_error_i = '0;

        // Randomized traffic: sel = addr % 4, each port answers its own requests in order.
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        hold = 1'b0;
        while (rcvd < NREQ && cyc < 40000) begin
            if (!hold) begin
                if (sent < NREQ && $urandom_range(0, 3) != 0) begin
                    a = $urandom;
                    set_req(1'b1, a[1:0], a, 1'($urandom));
                    slv_q_amo_i  = 4'($urandom);
                    slv_q_data_i = $urandom;
                    slv_q_strb_i = 4'($urandom);
                    slv_q_size_i = 2'($urandom);
                end else begin
                    slv_q_valid_i = 1'b0;
                end
            end
            mst_q_ready_i = 4'($urandom);
            for (int i = 0; i < NP; i++) begin
                if (pend[i].size() > 0 && $urandom_range(0, 2) != 0) begin
                    mst_p_valid_i[i] = 1'b1;
                    {mst_p_error_i[i], mst_p_data_i[i*DW +: DW]} = rsp_of(pend[i][0]);
                end else begin
                    mst_p_valid_i[i] = 1'b0;
                    mst_p_error_i[i] = 1'($urandom);
                    mst_p_data_i[i*DW +: DW] = $urandom;
                end
            end
            slv_p_ready_i = ($urandom_range(0, 3) != 0);
            check_cycle();

            hold = slv_q_valid_i && !slv_q_ready_o;
            if (slv_q_valid_i && slv_q_ready_o) begin
                sent++;
                exp_rsp.push_back(rsp_of(slv_q_addr_i));
            end
            for (int i = 0; i < NP; i++) begin
                if (mst_q_valid_o[i] && mst_q_ready_i[i]) begin
                    check_eq("route", 128'(mst_q_addr_o[i*AW +: 2]), 128'(i));
                    pend[i].push_back(mst_q_addr_o[i*AW +: AW]);
                end
                if (mst_p_valid_i[i] && mst_p_ready_o[i] && pend[i].size() > 0) begin
                    void'(pend[i].pop_front());
                end
            end
            if (slv_p_valid_o && slv_p_ready_i) begin
                exp_v = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : {33{1'bx}};
                check_eq("e2e_rsp", 128'({slv_p_error_o, slv_p_data_o}), 128'(exp_v));
                rcvd++;
            end
            cyc++;
            @(negedge clk_i);
        end

        check_eq("rsp_count", 128'(rcvd), 128'(NREQ));
        total = m_q.size() + exp_rsp.size();
        for (int i = 0; i < NP; i++) total += pend[i].size();
        check_eq("queues_empty", 128'(total), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
